// File: rtl/du_pkg.sv
// Shared constants for the debug unit: host command bytes, reply codes,
// one-hot sequencer states and the UART FIFO port owner select.
package du_pkg;

   localparam logic [7:0] CMD_LOAD = 8'h4C;
   localparam logic [7:0] CMD_RUN  = 8'h52;
   localparam logic [7:0] CMD_STEP = 8'h53;
   localparam logic [7:0] CMD_DUMP = 8'h44;
   localparam logic [7:0] CMD_HALT = 8'h48;

   localparam logic [7:0] ACK = 8'h05;
   localparam logic [7:0] NAK = 8'h15;

   localparam logic [5:0] ST_IDLE  = 6'b000001;
   localparam logic [5:0] ST_LOAD  = 6'b000010;
   localparam logic [5:0] ST_RUN   = 6'b000100;
   localparam logic [5:0] ST_STEP  = 6'b001000;
   localparam logic [5:0] ST_DUMP  = 6'b010000;
   localparam logic [5:0] ST_REPLY = 6'b100000;

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_SEQ  = 2'd1,
      SEL_LOAD = 2'd2,
      SEL_DUMP = 2'd3
   } sel_e;

endpackage

// File: rtl/du_watchdog.sv
// Stall watchdog: counts enabled cycles since the last clear and flags
// expiry at TIMEOUT_CYCLES-1; the count saturates rather than wrapping.
module du_watchdog #(
   parameter int NB_TIMEOUT     = 32,
   parameter int TIMEOUT_CYCLES = 100_000_000
) (
   input  logic clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_clr,
   output logic o_expire
);

   localparam logic [NB_TIMEOUT-1:0] LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

   logic [NB_TIMEOUT-1:0] count;

   always_ff @(posedge clk) begin
      if (i_rst || !i_en || i_clr)
         count <= '0;
      else if (count != LAST)
         count <= count + 1'b1;
   end

   // A kick in the expiry cycle wins over the timeout
   assign o_expire = i_en && !i_clr && (count == LAST);

endmodule

// File: rtl/du_cmd_sequencer.sv
// Debug unit command sequencer: decodes host bytes, dispatches loader or
// dumper, drives CPU run/step and owns the shared UART FIFO port.
module du_cmd_sequencer
   import du_pkg::*;
#(
   parameter int NB_UART_DATA   = 8,
   parameter int NB_TIMEOUT     = 32,
   parameter int TIMEOUT_CYCLES = 100_000_000
) (
   input  logic                    clk,
   input  logic                    i_rst,
   input  logic                    i_rx_done,
   input  logic [NB_UART_DATA-1:0] i_rx_data,
   input  logic                    i_tx_full,
   output logic                    o_rd,
   output logic                    o_wr,
   output logic [NB_UART_DATA-1:0] o_wdata,
   output logic                    o_tx_start,
   output logic                    o_load_start,
   output logic                    o_load_abort,
   input  logic                    i_load_done,
   input  logic                    i_load_rd,
   input  logic                    i_load_wr,
   input  logic                    i_load_tx_start,
   input  logic [NB_UART_DATA-1:0] i_load_wdata,
   output logic                    o_dump_start,
   output logic                    o_dump_abort,
   input  logic                    i_dump_done,
   input  logic                    i_dump_wr,
   input  logic                    i_dump_tx_start,
   input  logic [NB_UART_DATA-1:0] i_dump_wdata,
   output logic                    o_cpu_en,
   output logic                    o_cpu_step,
   input  logic                    i_cpu_halt,
   output logic                    o_busy
);

   logic [5:0]              state, next_state;
   logic [NB_UART_DATA-1:0] reply_reg;
   sel_e                    sel;
   logic                    seq_rd, seq_wr, wd_en, wd_clr, wd_expire;

   du_watchdog #(
      .NB_TIMEOUT     (NB_TIMEOUT),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk      (clk),
      .i_rst    (i_rst),
      .i_en     (wd_en),
      .i_clr    (wd_clr),
      .o_expire (wd_expire)
   );

   assign wd_en  = (state == ST_LOAD) || (state == ST_DUMP);
   assign wd_clr = ((state == ST_LOAD) && i_rx_done) || ((state == ST_DUMP) && i_dump_wr);

   // The abort pulse cycle is the first REPLY cycle; the NAK goes out after it
   assign seq_rd = ((state == ST_IDLE) || (state == ST_RUN)) && i_rx_done;
   assign seq_wr = (state == ST_REPLY) && !i_tx_full && !o_load_abort && !o_dump_abort;

   always_comb begin
      next_state = state;
      unique case (state)
         ST_IDLE:
            if (i_rx_done) begin
               case (i_rx_data)
                  CMD_LOAD: next_state = ST_LOAD;
                  CMD_RUN:  next_state = ST_RUN;
                  CMD_STEP: next_state = ST_STEP;
                  CMD_DUMP: next_state = ST_DUMP;
                  default:  next_state = ST_REPLY;
               endcase
            end
         ST_LOAD:
            if (i_load_done)    next_state = ST_IDLE;
            else if (wd_expire) next_state = ST_REPLY;
         ST_RUN:
            if (i_cpu_halt || (i_rx_done && (i_rx_data == CMD_HALT)))
               next_state = ST_DUMP;
         ST_STEP:
            next_state = ST_DUMP;
         ST_DUMP:
            if (i_dump_done)    next_state = ST_IDLE;
            else if (wd_expire) next_state = ST_REPLY;
         ST_REPLY:
            if (seq_wr) next_state = ST_IDLE;
         default:
            next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state        <= ST_IDLE;
         reply_reg    <= NAK;
         o_load_start <= 1'b0;
         o_dump_start <= 1'b0;
         o_load_abort <= 1'b0;
         o_dump_abort <= 1'b0;
      end else begin
         state        <= next_state;
         o_load_start <= (next_state == ST_LOAD) && (state != ST_LOAD);
         o_dump_start <= (next_state == ST_DUMP) && (state != ST_DUMP);
         o_load_abort <= (state == ST_LOAD) && (next_state == ST_REPLY);
         o_dump_abort <= (state == ST_DUMP) && (next_state == ST_REPLY);
         if ((next_state == ST_REPLY) && (state != ST_REPLY))
            reply_reg <= NAK;
      end
   end

   always_comb begin
      unique case (state)
         ST_IDLE, ST_RUN, ST_STEP, ST_REPLY: sel = SEL_SEQ;
         ST_LOAD:                            sel = SEL_LOAD;
         ST_DUMP:                            sel = SEL_DUMP;
         default:                            sel = SEL_NONE;
      endcase
   end

   always_comb begin
      o_rd       = 1'b0;
      o_wr       = 1'b0;
      o_wdata    = '0;
      o_tx_start = 1'b0;
      unique case (sel)
         SEL_SEQ: begin
            o_rd       = seq_rd;
            o_wr       = seq_wr;
            o_tx_start = seq_wr;
            o_wdata    = seq_wr ? reply_reg : '0;
         end
         SEL_LOAD: begin
            o_rd       = i_load_rd;
            o_wr       = i_load_wr;
            o_tx_start = i_load_tx_start;
            o_wdata    = i_load_wdata;
         end
         SEL_DUMP: begin
            o_wr       = i_dump_wr;
            o_tx_start = i_dump_tx_start;
            o_wdata    = i_dump_wdata;
         end
         default: ;
      endcase
   end

   assign o_cpu_en   = (state == ST_RUN);
   assign o_cpu_step = (state == ST_STEP);
   assign o_busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_du_cmd_sequencer.sv
// Directed bench for du_cmd_sequencer: stimulus queues expected TX bytes,
// a forked monitor pops and compares on every o_wr push.
module tb_du_cmd_sequencer;

   logic       clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_rx_done = 1'b0;
   logic [7:0] i_rx_data = 8'h00;
   logic       i_tx_full = 1'b0;
   logic       o_rd, o_wr, o_tx_start;
   logic [7:0] o_wdata;
   logic       o_load_start, o_load_abort, o_dump_start, o_dump_abort;
   logic       i_load_done = 1'b0, i_load_rd = 1'b0, i_load_wr = 1'b0, i_load_tx_start = 1'b0;
   logic [7:0] i_load_wdata = 8'h00;
   logic       i_dump_done = 1'b0, i_dump_wr = 1'b0, i_dump_tx_start = 1'b0;
   logic [7:0] i_dump_wdata = 8'h00;
   logic       o_cpu_en, o_cpu_step, o_busy;
   logic       i_cpu_halt = 1'b0;

   int         errors = 0;
   int         checks = 0;
   int         cpu_en_seen = 0;
   int         abort_cnt = 0;
   int         abort_snap;
   logic [7:0] exp_q[$];
   logic [7:0] exp_b;

   always #5 clk = ~clk;

   du_cmd_sequencer #(
      .NB_UART_DATA   (8),
      .NB_TIMEOUT     (32),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk             (clk),
      .i_rst           (i_rst),
      .i_rx_done       (i_rx_done),
      .i_rx_data       (i_rx_data),
      .i_tx_full       (i_tx_full),
      .o_rd            (o_rd),
      .o_wr            (o_wr),
      .o_wdata         (o_wdata),
      .o_tx_start      (o_tx_start),
      .o_load_start    (o_load_start),
      .o_load_abort    (o_load_abort),
      .i_load_done     (i_load_done),
      .i_load_rd       (i_load_rd),
      .i_load_wr       (i_load_wr),
      .i_load_tx_start (i_load_tx_start),
      .i_load_wdata    (i_load_wdata),
      .o_dump_start    (o_dump_start),
      .o_dump_abort    (o_dump_abort),
      .i_dump_done     (i_dump_done),
      .i_dump_wr       (i_dump_wr),
      .i_dump_tx_start (i_dump_tx_start),
      .i_dump_wdata    (i_dump_wdata),
      .o_cpu_en        (o_cpu_en),
      .o_cpu_step      (o_cpu_step),
      .i_cpu_halt      (i_cpu_halt),
      .o_busy          (o_busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [18:0] all_outs();
      return {o_rd, o_wr, o_wdata, o_tx_start, o_load_start, o_load_abort,
              o_dump_start, o_dump_abort, o_cpu_en, o_cpu_step, o_busy};
   endfunction

   initial begin
      #200000;
      $display("FAIL sim_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      fork
         forever begin
            @(negedge clk);
            if (o_cpu_en) cpu_en_seen++;
            if (o_load_abort || o_dump_abort) abort_cnt++;
            if (o_wr) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL tx_unexpected: got push %0h expected no push at %0t", o_wdata, $time);
               end else begin
                  exp_b = exp_q.pop_front();
                  chk("tx_byte", {24'h0, o_wdata}, {24'h0, exp_b});
               end
            end
         end
      join_none

      // reset
      cyc(); cyc();
      i_rst = 1'b0;
      @(negedge clk); chk("reset_outs", {13'h0, all_outs()}, 32'h0);

      // requests from unselected sub-units are ignored in IDLE
      cyc();
      i_load_wr = 1'b1; i_dump_wr = 1'b1; i_load_wdata = 8'h11; i_dump_wdata = 8'hAA;
      @(negedge clk); chk("idle_ignore_wr", o_wr, 0);
      cyc();
      i_load_wr = 1'b0; i_dump_wr = 1'b0;

      // LOAD
      i_rx_done = 1'b1; i_rx_data = 8'h4C;
      @(negedge clk); chk("load_rd", o_rd, 1); chk("load_start_early", o_load_start, 0);
      cyc();
      i_rx_done = 1'b0;
      @(negedge clk); chk("load_start", o_load_start, 1); chk("load_busy", o_busy, 1);
      cyc();
      i_load_wr = 1'b1; i_load_tx_start = 1'b1; i_load_wdata = 8'h05; exp_q.push_back(8'h05);
      @(negedge clk); chk("load_start_once", o_load_start, 0); chk("load_tx_start", o_tx_start, 1);
      cyc();
      i_load_wr = 1'b0; i_load_tx_start = 1'b0; i_load_done = 1'b1;
      @(negedge clk); chk("load_busy_done", o_busy, 1);
      cyc();
      i_load_done = 1'b0;
      @(negedge clk); chk("load_idle", o_busy, 0);

      // unknown byte -> NAK, held back by a full TX FIFO
      cyc();
      i_rx_done = 1'b1; i_rx_data = 8'h7A; i_tx_full = 1'b1;
      cyc();
      i_rx_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); chk("nak_wait_wr", o_wr, 0); chk("nak_wait_busy", o_busy, 1);
         cyc();
      end
      i_tx_full = 1'b0; exp_q.push_back(8'h15);
      @(negedge clk); chk("nak_tx_start", o_tx_start, 1);
      cyc();
      @(negedge clk); chk("nak_idle", o_busy, 0); chk("nak_single", o_wr, 0);

      // STEP, halt ignored
      cpu_en_seen = 0;
      cyc();
      i_rx_done = 1'b1; i_rx_data = 8'h53;
      cyc();
      i_rx_done = 1'b0; i_cpu_halt = 1'b1;
      @(negedge clk); chk("step_pulse", o_cpu_step, 1); chk("step_dump_start_early", o_dump_start, 0);
      cyc();
      i_cpu_halt = 1'b0;
      i_dump_wr = 1'b1; i_dump_tx_start = 1'b1; i_dump_wdata = 8'h3C; exp_q.push_back(8'h3C);
      @(negedge clk); chk("step_once", o_cpu_step, 0); chk("step_dump_start", o_dump_start, 1);
      cyc();
      i_dump_wr = 1'b0; i_dump_tx_start = 1'b0; i_dump_done = 1'b1;
      @(negedge clk); chk("dump_start_once", o_dump_start, 0); chk("dump_no_rd", o_rd, 0);
      cyc();
      i_dump_done = 1'b0;
      @(negedge clk); chk("step_idle", o_busy, 0); chk("step_no_cpu_en", cpu_en_seen, 0);

      // RUN, discard a byte, stop on CPU halt
      cyc();
      i_rx_done = 1'b1; i_rx_data = 8'h52;
      cyc();
      i_rx_data = 8'h41;
      @(negedge clk); chk("run_en", o_cpu_en, 1); chk("run_discard_rd", o_rd, 1);
      cyc();
      i_rx_done = 1'b0;
      @(negedge clk); chk("run_stays", o_cpu_en, 1); chk("run_no_dump", o_dump_start, 0);
      cyc();
      i_cpu_halt = 1'b1;
      @(negedge clk); chk("run_halt_cycle", o_cpu_en, 1);
      cyc();
      i_cpu_halt = 1'b0;
      @(negedge clk); chk("run_en_drop", o_cpu_en, 0); chk("run_dump_start", o_dump_start, 1);
      i_dump_done = 1'b1;
      cyc();
      i_dump_done = 1'b0;
      @(negedge clk); chk("run_idle", o_busy, 0);

      // RUN stopped by host 'H'
      cyc();
      i_rx_done = 1'b1; i_rx_data = 8'h52;
      cyc();
      i_rx_data = 8'h48;
      @(negedge clk); chk("halt_rd", o_rd, 1);
      cyc();
      i_rx_done = 1'b0;
      @(negedge clk); chk("halt_en_drop", o_cpu_en, 0); chk("halt_dump_start", o_dump_start, 1);
      i_dump_done = 1'b1;
      cyc();
      i_dump_done = 1'b0;
      @(negedge clk); chk("halt_idle", o_busy, 0);

      // LOAD watchdog with a restart at cycle 10
      cyc();
      i_rx_done = 1'b1; i_rx_data = 8'h4C;
      cyc();
      i_rx_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); chk("wd_pre_kick", o_load_abort, 0);
         cyc();
      end
      i_rx_done = 1'b1; i_rx_data = 8'h00;
      cyc();
      i_rx_done = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk); chk("wd_no_abort", o_load_abort, 0); chk("wd_busy", o_busy, 1);
         cyc();
      end
      @(negedge clk); chk("wd_abort", o_load_abort, 1); chk("wd_abort_no_wr", o_wr, 0);
      cyc();
      exp_q.push_back(8'h15);
      @(negedge clk); chk("wd_abort_once", o_load_abort, 0); chk("wd_nak_wr", o_wr, 1);
      cyc();
      @(negedge clk); chk("wd_idle", o_busy, 0);

      // reset while in DUMP
      abort_snap = abort_cnt;
      cyc();
      i_rx_done = 1'b1; i_rx_data = 8'h53;
      cyc();
      i_rx_done = 1'b0;
      cyc();
      i_rst = 1'b1;
      @(negedge clk); chk("rst_in_dump", o_busy, 1);
      cyc();
      @(negedge clk); chk("rst_outs", {13'h0, all_outs()}, 32'h0);
      i_rst = 1'b0;
      cyc(); cyc();
      @(negedge clk); chk("rst_no_abort", abort_cnt, abort_snap); chk("rst_idle", o_busy, 0);

      chk("tx_queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
